// File: rtl/rsync_ctrl_pkg.sv
// Shared widths, code clamp limit and sequencer state encoding for rsync_ctrl.
// Combinational constants only; no latency or backpressure of its own.
package rsync_ctrl_pkg;

  localparam int THERM_W = 17;
  localparam int BIN_W   = 7;
  localparam int CODE_W  = 12;

  // Largest code whose MSB segment index (code >> 7) still fits 17 thermometer bits.
  localparam logic [CODE_W-1:0] CODE_MAX = 12'd2303;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PWRUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_PWRDN = 2'd3
  } state_e;

endpackage

// File: rtl/rsync_seg_encoder.sv
// Clamps a DAC code to CODE_MAX and splits it into thermometer MSBs and binary LSBs.
// Purely combinational (zero latency); no handshake, the caller decides when to register.
module rsync_seg_encoder
  import rsync_ctrl_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [THERM_W-1:0] therm,
  output logic [BIN_W-1:0]   bin,
  output logic               sat
);

  logic [CODE_W-1:0] clamped;
  logic [4:0]        seg;

  always_comb begin
    sat     = (code > CODE_MAX);
    clamped = sat ? CODE_MAX : code;
    seg     = clamped[CODE_W-1:BIN_W];
    bin     = clamped[BIN_W-1:0];
    therm   = '0;
    for (int i = 0; i < THERM_W; i++) begin
      therm[i] = (5'(i) < seg);
    end
  end

endmodule

// File: rtl/rsync_ctrl.sv
// Power sequencer, code scheduler (1-cycle code->data latency, code_ready only in RUN)
// and ATB reconfiguration arbiter (requests ignored while a settle window is open).
module rsync_ctrl
  import rsync_ctrl_pkg::*;
#(
  parameter int PWRUP_CYC      = 64,
  parameter int CLKEN_DLY      = 32,
  parameter int PWRDN_CYC      = 16,
  parameter int ATB_SETTLE_CYC = 8
) (
  input  logic               clkin,
  input  logic               rstb,
  input  logic               en,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               code_valid,
  output logic               code_ready,
  output logic               pdb,
  output logic               clk_en,
  output logic [THERM_W-1:0] dataintherm,
  output logic [THERM_W-1:0] datainthermb,
  output logic [BIN_W-1:0]   datainbin,
  output logic [BIN_W-1:0]   datainbinb,
  input  logic               atb_req,
  input  logic [1:0]         atb_sel,
  output logic [1:0]         atb_ena,
  output logic               atb_ack,
  output logic               sat,
  output logic               underrun,
  output logic [1:0]         state
);

  localparam int CNT_MAX = (PWRUP_CYC > PWRDN_CYC) ? PWRUP_CYC : PWRDN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int ACNT_W  = $clog2(ATB_SETTLE_CYC + 1);

  localparam logic [CNT_W-1:0]  PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
  localparam logic [CNT_W-1:0]  PWRDN_LAST = CNT_W'(PWRDN_CYC - 1);
  localparam logic [CNT_W-1:0]  CLKEN_AT   = CNT_W'(CLKEN_DLY);
  localparam logic [ACNT_W-1:0] ATB_LAST   = ACNT_W'(ATB_SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pdb_q, pdb_d;
  logic               clk_en_q, clk_en_d;
  logic               code_ready_q, code_ready_d;
  logic [THERM_W-1:0] therm_q, therm_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               sat_q, sat_d;
  logic               underrun_q, underrun_d;
  logic [1:0]         atb_ena_q, atb_ena_d;
  logic               atb_busy_q, atb_busy_d;
  logic [ACNT_W-1:0]  atb_cnt_q, atb_cnt_d;
  logic               atb_ack_q, atb_ack_d;

  logic [THERM_W-1:0] enc_therm;
  logic [BIN_W-1:0]   enc_bin;
  logic               enc_sat;
  logic               accept;

  rsync_seg_encoder u_enc (
    .code  (code_in),
    .therm (enc_therm),
    .bin   (enc_bin),
    .sat   (enc_sat)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (en) state_d = ST_PWRUP;
      ST_PWRUP: begin
        if (!en)                      state_d = ST_PWRDN;
        else if (cnt_q == PWRUP_LAST) state_d = ST_RUN;
      end
      ST_RUN:   if (!en) state_d = ST_PWRDN;
      ST_PWRDN: if (cnt_q == PWRDN_LAST) state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_PWRUP || state_q == ST_PWRDN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A code offered while en drops is dropped: the bank is about to be flushed.
    accept = (state_q == ST_RUN) && en && code_valid;

    pdb_d        = (state_d != ST_OFF);
    code_ready_d = (state_d == ST_RUN);
    clk_en_d     = (state_d == ST_RUN) || (state_d == ST_PWRDN) ||
                   ((state_d == ST_PWRUP) && (cnt_d >= CLKEN_AT));

    therm_d = therm_q;
    bin_d   = bin_q;
    if (state_d != ST_RUN) begin
      therm_d = '0;
      bin_d   = '0;
    end else if (accept) begin
      therm_d = enc_therm;
      bin_d   = enc_bin;
    end
    sat_d = accept && enc_sat;

    underrun_d = underrun_q;
    if (state_q != ST_RUN && state_d == ST_RUN) begin
      underrun_d = 1'b0;
    end else if (state_q == ST_RUN && !code_valid) begin
      underrun_d = 1'b1;
    end
  end

  // ATB arbiter runs regardless of power state; atb_ena survives power-down.
  always_comb begin
    atb_ena_d  = atb_ena_q;
    atb_busy_d = atb_busy_q;
    atb_cnt_d  = atb_cnt_q;
    atb_ack_d  = 1'b0;
    if (atb_busy_q) begin
      if (atb_cnt_q == ATB_LAST) begin
        atb_ack_d  = 1'b1;
        atb_busy_d = 1'b0;
      end else begin
        atb_cnt_d = atb_cnt_q + ACNT_W'(1);
      end
    end else if (atb_req) begin
      atb_ena_d  = atb_sel;
      atb_busy_d = 1'b1;
      atb_cnt_d  = '0;
    end
  end

  always_ff @(posedge clkin or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_OFF;
      cnt_q        <= '0;
      pdb_q        <= 1'b0;
      clk_en_q     <= 1'b0;
      code_ready_q <= 1'b0;
      therm_q      <= '0;
      bin_q        <= '0;
      sat_q        <= 1'b0;
      underrun_q   <= 1'b0;
      atb_ena_q    <= '0;
      atb_busy_q   <= 1'b0;
      atb_cnt_q    <= '0;
      atb_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pdb_q        <= pdb_d;
      clk_en_q     <= clk_en_d;
      code_ready_q <= code_ready_d;
      therm_q      <= therm_d;
      bin_q        <= bin_d;
      sat_q        <= sat_d;
      underrun_q   <= underrun_d;
      atb_ena_q    <= atb_ena_d;
      atb_busy_q   <= atb_busy_d;
      atb_cnt_q    <= atb_cnt_d;
      atb_ack_q    <= atb_ack_d;
    end
  end

  assign state        = state_q;
  assign pdb          = pdb_q;
  assign clk_en       = clk_en_q;
  assign code_ready   = code_ready_q;
  assign dataintherm  = therm_q;
  assign datainthermb = ~therm_q;
  assign datainbin    = bin_q;
  assign datainbinb   = ~bin_q;
  assign sat          = sat_q;
  assign underrun     = underrun_q;
  assign atb_ena      = atb_ena_q;
  assign atb_ack      = atb_ack_q;

endmodule

// File: tb/tb_rsync_ctrl.sv
// Directed power/encode/ATB sequences followed by random traffic, all compared
// every cycle against a timeline-based behavioural model of rsync_ctrl.
module tb_rsync_ctrl;

  localparam int PWRUP_CYC      = 64;
  localparam int CLKEN_DLY      = 32;
  localparam int PWRDN_CYC      = 16;
  localparam int ATB_SETTLE_CYC = 8;

  localparam int P_OFF = 0, P_UP = 1, P_RUN = 2, P_DN = 3;

  logic        clkin = 1'b0;
  logic        rstb;
  logic        en;
  logic [11:0] code_in;
  logic        code_valid;
  logic        atb_req;
  logic [1:0]  atb_sel;
  logic        code_ready, pdb, clk_en, atb_ack, sat, underrun;
  logic [16:0] dataintherm, datainthermb;
  logic [6:0]  datainbin, datainbinb;
  logic [1:0]  atb_ena, state;

  int checks   = 0;
  int failures = 0;

  rsync_ctrl #(
    .PWRUP_CYC      (PWRUP_CYC),
    .CLKEN_DLY      (CLKEN_DLY),
    .PWRDN_CYC      (PWRDN_CYC),
    .ATB_SETTLE_CYC (ATB_SETTLE_CYC)
  ) dut (
    .clkin        (clkin),
    .rstb         (rstb),
    .en           (en),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .pdb          (pdb),
    .clk_en       (clk_en),
    .dataintherm  (dataintherm),
    .datainthermb (datainthermb),
    .datainbin    (datainbin),
    .datainbinb   (datainbinb),
    .atb_req      (atb_req),
    .atb_sel      (atb_sel),
    .atb_ena      (atb_ena),
    .atb_ack      (atb_ack),
    .sat          (sat),
    .underrun     (underrun),
    .state        (state)
  );

  always #5 clkin = ~clkin;

  // Reference model: phase plus cycles elapsed in that phase, data as integers.
  int          m_phase;
  int          m_elapsed;
  logic [16:0] m_therm;
  logic [6:0]  m_bin;
  logic        m_sat;
  logic        m_under;
  logic [1:0]  m_ena;
  int          m_atb_left;
  logic        m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase    = P_OFF;
    m_elapsed  = 0;
    m_therm    = '0;
    m_bin      = '0;
    m_sat      = 1'b0;
    m_under    = 1'b0;
    m_ena      = 2'b00;
    m_atb_left = 0;
    m_ack      = 1'b0;
  endfunction

  function automatic void model_step();
    int nxt;
    int c;
    int seg;
    nxt   = m_phase;
    m_sat = 1'b0;
    case (m_phase)
      P_OFF: if (en) nxt = P_UP;
      P_UP: begin
        if (!en) nxt = P_DN;
        else if (m_elapsed + 1 == PWRUP_CYC) nxt = P_RUN;
      end
      P_RUN: begin
        if (!code_valid) m_under = 1'b1;
        if (!en) nxt = P_DN;
        else if (code_valid) begin
          c       = (int'(code_in) > 2303) ? 2303 : int'(code_in);
          seg     = c / 128;
          m_therm = 17'((32'd1 << seg) - 32'd1);
          m_bin   = 7'(c % 128);
          m_sat   = (int'(code_in) > 2303);
        end
      end
      default: if (m_elapsed + 1 == PWRDN_CYC) nxt = P_OFF;
    endcase
    if (nxt != m_phase) begin
      m_elapsed = 0;
      if (nxt == P_RUN) m_under = 1'b0;
    end else begin
      m_elapsed++;
    end
    if (nxt != P_RUN) begin
      m_therm = '0;
      m_bin   = '0;
    end
    m_phase = nxt;

    m_ack = 1'b0;
    if (m_atb_left > 0) begin
      m_atb_left--;
      if (m_atb_left == 0) m_ack = 1'b1;
    end else if (atb_req) begin
      m_ena      = atb_sel;
      m_atb_left = ATB_SETTLE_CYC;
    end
  endfunction

  task automatic compare_all();
    logic [16:0] exp_thb;
    logic [6:0]  exp_bnb;
    logic        exp_clk_en;
    exp_thb    = ~m_therm;
    exp_bnb    = ~m_bin;
    exp_clk_en = (m_phase == P_RUN) || (m_phase == P_DN) ||
                 ((m_phase == P_UP) && (m_elapsed >= CLKEN_DLY));
    check("state",        state,        m_phase);
    check("pdb",          pdb,          m_phase != P_OFF);
    check("clk_en",       clk_en,       exp_clk_en);
    check("code_ready",   code_ready,   m_phase == P_RUN);
    check("dataintherm",  dataintherm,  m_therm);
    check("datainthermb", datainthermb, exp_thb);
    check("datainbin",    datainbin,    m_bin);
    check("datainbinb",   datainbinb,   exp_bnb);
    check("sat",          sat,          m_sat);
    check("underrun",     underrun,     m_under);
    check("atb_ena",      atb_ena,      m_ena);
    check("atb_ack",      atb_ack,      m_ack);
  endtask

  task automatic step();
    @(posedge clkin);
    model_step();
    @(negedge clkin);
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    @(negedge clkin);
    rstb = 1'b0;
    #1;
    model_reset();
    compare_all();
    #1;
    rstb = 1'b1;
  endtask

  initial begin
    rstb       = 1'b0;
    en         = 1'b0;
    code_in    = '0;
    code_valid = 1'b0;
    atb_req    = 1'b0;
    atb_sel    = 2'b00;
    model_reset();
    repeat (3) @(negedge clkin);
    compare_all();
    rstb = 1'b1;
    steps(10);
    check("off_state", state, 0);

    // Power-up timeline
    en = 1'b1;
    step();
    check("pdb_rise_1cyc", pdb, 1);
    check("clk_en_early", clk_en, 0);
    steps(CLKEN_DLY - 1);
    check("clk_en_before", clk_en, 0);
    step();
    check("clk_en_rise", clk_en, 1);
    steps(PWRUP_CYC - CLKEN_DLY - 1);
    check("not_run_yet", state, 1);
    step();
    check("run_entry", state, 2);

    code_in = 12'd1234; code_valid = 1'b1;
    step();
    check("therm_1234", dataintherm, 17'h001FF);
    check("bin_1234", datainbin, 7'h52);
    code_in = 12'd2303;
    step();
    check("therm_max", dataintherm, 17'h1FFFF);
    check("bin_max", datainbin, 7'h7F);
    check("sat_2303", sat, 0);
    code_in = 12'd4095;
    step();
    check("therm_sat", dataintherm, 17'h1FFFF);
    check("sat_4095", sat, 1);
    code_valid = 1'b0;
    steps(3);
    check("sat_pulse_end", sat, 0);
    check("underrun_sticky", underrun, 1);
    check("therm_held", dataintherm, 17'h1FFFF);

    // Power-down flush
    en = 1'b0; code_valid = 1'b1; code_in = 12'd100;
    step();
    check("pwrdn_data0", dataintherm, 0);
    check("pwrdn_clk_en", clk_en, 1);
    steps(PWRDN_CYC - 1);
    check("pwrdn_last_pdb", pdb, 1);
    step();
    check("off_pdb", pdb, 0);
    check("off_clk_en", clk_en, 0);

    // ATB handshake with a mid-settle select change
    atb_req = 1'b1; atb_sel = 2'b10;
    step();
    check("atb_update", atb_ena, 2'b10);
    atb_sel = 2'b01;
    steps(ATB_SETTLE_CYC - 1);
    check("atb_ignored", atb_ena, 2'b10);
    step();
    check("atb_ack", atb_ack, 1);
    step();
    check("atb_rerequest", atb_ena, 2'b01);
    atb_req = 1'b0;
    steps(ATB_SETTLE_CYC + 2);

    // Power-up abort at counter 10
    en = 1'b1;
    steps(11);
    en = 1'b0;
    step();
    check("abort_pwrdn", state, 3);
    steps(PWRDN_CYC);
    check("abort_off", state, 0);

    // Async reset while running
    en = 1'b1; code_valid = 1'b1; code_in = 12'd3000;
    steps(PWRUP_CYC + 4);
    check("run_before_rst", state, 2);
    async_reset();
    check("rst_pdb", pdb, 0);
    check("rst_thermb", datainthermb, 17'h1FFFF);

    // Random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      code_valid = ($urandom_range(0, 9) != 0);
      code_in    = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(2290, 4095))
                                               : 12'($urandom_range(0, 4095));
      atb_req    = ($urandom_range(0, 3) == 0);
      atb_sel    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
